// File: rtl/egress_drain_pkg.sv
// Shared definitions for the egress drain: FSM states and source identifiers.
package egress_drain_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam logic SRC_D0 = 1'b0;
    localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/egress_skid.sv
// Two-entry in-order skid buffer. Entry 0 is the head and keeps its last value once drained.
module egress_skid #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] e0_q, e1_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= push_data;
                    else                 e1_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    // With a single entry the head is left in place so data_out holds.
                    if (count_q == 2'd2) e0_q <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= push_data;
                    end else begin
                        e0_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign full  = (count_q == 2'd2);
    assign count = count_q;
    assign head  = e0_q;

endmodule

// File: rtl/egress_drain.sv
// Drains two destination FIFOs under weighted round-robin into one tagged, stallable stream.
module egress_drain
    import egress_drain_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned BURST     = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 empty_d0,
    input  logic                 empty_d1,
    input  logic [DATA_SIZE-1:0] data_d0,
    input  logic [DATA_SIZE-1:0] data_d1,
    input  logic                 stall,
    output logic                 pop_d0,
    output logic                 pop_d1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 dest_out,
    output logic                 valid_out,
    output logic                 idle_out,
    output logic [CNT_W-1:0]     cnt_d0,
    output logic [CNT_W-1:0]     cnt_d1
);

    localparam logic [2:0] BurstMax = 3'(BURST);

    state_e             state_q;
    logic               idle_q;
    logic               fly_q, fly_src_q;
    logic               rr_q;
    logic [2:0]         burst_q;
    logic [CNT_W-1:0]   cnt_d0_q, cnt_d1_q;

    logic               skid_full;
    logic [1:0]         skid_count;
    logic [DATA_SIZE:0] skid_head;
    logic [2:0]         occ;
    logic               xfer, credit, want, pop_src, pop_any;

    assign valid_out = (skid_count != 2'd0);
    assign data_out  = skid_head[DATA_SIZE-1:0];
    assign dest_out  = skid_head[DATA_SIZE];
    assign xfer      = valid_out & ~stall;

    // Occupancy after this cycle's removal, so an unstalled stream pops every cycle.
    assign occ    = {1'b0, skid_count} + {2'b00, fly_q} - {2'b00, xfer};
    assign credit = ~(skid_full & ~xfer) & (occ < 3'd2);

    always_comb begin
        want    = 1'b0;
        pop_src = rr_q;
        if (!empty_d0 && !empty_d1) begin
            want    = 1'b1;
            pop_src = (burst_q >= BurstMax) ? ~rr_q : rr_q;
        end else if (!empty_d0) begin
            want    = 1'b1;
            pop_src = SRC_D0;
        end else if (!empty_d1) begin
            want    = 1'b1;
            pop_src = SRC_D1;
        end
    end

    assign pop_any = (state_q == StRun) & enable & ~reset & credit & want;
    assign pop_d0  = pop_any & (pop_src == SRC_D0);
    assign pop_d1  = pop_any & (pop_src == SRC_D1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idle_q    <= 1'b1;
            fly_q     <= 1'b0;
            fly_src_q <= SRC_D0;
            rr_q      <= SRC_D0;
            burst_q   <= '0;
            cnt_d0_q  <= '0;
            cnt_d1_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StRun;
                        idle_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (!enable) state_q <= StFlush;
                end
                StFlush: begin
                    if (enable) begin
                        state_q <= StRun;
                    end else if (!fly_q && skid_count == 2'd0) begin
                        state_q <= StIdle;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    idle_q  <= 1'b1;
                end
            endcase

            fly_q     <= pop_any;
            fly_src_q <= pop_src;

            if (pop_any) begin
                if (pop_src == rr_q) begin
                    if (burst_q < BurstMax) burst_q <= burst_q + 3'd1;
                end else begin
                    rr_q    <= pop_src;
                    burst_q <= 3'd1;
                end
            end

            if (xfer) begin
                if (dest_out == SRC_D0) cnt_d0_q <= cnt_d0_q + CNT_W'(1);
                else                    cnt_d1_q <= cnt_d1_q + CNT_W'(1);
            end
        end
    end

    assign idle_out = idle_q;
    assign cnt_d0   = cnt_d0_q;
    assign cnt_d1   = cnt_d1_q;

    egress_skid #(
        .WIDTH(DATA_SIZE + 1)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (fly_q),
        .push_data({fly_src_q, fly_src_q ? data_d1 : data_d0}),
        .pop      (xfer),
        .full     (skid_full),
        .count    (skid_count),
        .head     (skid_head)
    );

endmodule

// File: tb/tb_egress_drain.sv
// Directed and randomized bench for egress_drain against a queue-based reference model.
module tb_egress_drain;

    localparam int unsigned DW    = 6;
    localparam int unsigned BURST = 2;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset, enable, empty_d0, empty_d1, stall;
    logic [DW-1:0] data_d0, data_d1, data_out;
    logic          pop_d0, pop_d1, dest_out, valid_out, idle_out;
    logic [CW-1:0] cnt_d0, cnt_d1;

    always #5 clk = ~clk;

    egress_drain #(
        .DATA_SIZE(DW),
        .BURST    (BURST),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .empty_d0 (empty_d0),
        .empty_d1 (empty_d1),
        .data_d0  (data_d0),
        .data_d1  (data_d1),
        .stall    (stall),
        .pop_d0   (pop_d0),
        .pop_d1   (pop_d1),
        .data_out (data_out),
        .dest_out (dest_out),
        .valid_out(valid_out),
        .idle_out (idle_out),
        .cnt_d0   (cnt_d0),
        .cnt_d1   (cnt_d1)
    );

    typedef struct {
        logic          src;
        logic [DW-1:0] data;
        int            cyc;
    } ent_t;

    ent_t          sb[$];
    logic [DW-1:0] q0[$], q1[$];
    int            pop_cyc[$];
    bit            pop_src_log[$];

    int            checks = 0, failures = 0, cyc = 0;
    bit            run_m = 1'b0, idle_m = 1'b1, lat_chk = 1'b0, last_src = 1'b0;
    int            run_len = 0, cnt0_m = 0, cnt1_m = 0;
    logic [DW-1:0] last_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at negedge, then apply FIFO read data after posedge.
    task automatic step();
        ent_t          e;
        logic [DW-1:0] w;
        bit            p0, p1, v, xf, src;
        int            occ;
        w = '0;
        empty_d0 = (q0.size() == 0);
        empty_d1 = (q1.size() == 0);
        @(negedge clk);
        cyc++;
        p0  = pop_d0;
        p1  = pop_d1;
        v   = valid_out;
        xf  = v && !stall;
        occ = sb.size();
        check("idle_out", 32'(idle_out), 32'(idle_m));
        check("cnt_d0", 32'(cnt_d0), 32'(cnt0_m));
        check("cnt_d1", 32'(cnt_d1), 32'(cnt1_m));
        check("dual_pop", 32'(p0 & p1), 32'd0);
        if (!(run_m && enable && !reset)) check("pop_gated", 32'({p0, p1}), 32'd0);
        if (p0) check("pop_empty_d0", 32'(empty_d0), 32'd0);
        if (p1) check("pop_empty_d1", 32'(empty_d1), 32'd0);
        if (v) begin
            if (occ == 0) begin
                check("valid_spurious", 32'(v), 32'd0);
            end else begin
                check("data_out", 32'(data_out), 32'(sb[0].data));
                check("dest_out", 32'(dest_out), 32'(sb[0].src));
            end
        end else begin
            check("data_hold", 32'(data_out), 32'(last_word));
        end
        if (xf && occ > 0) begin
            e = sb.pop_front();
            last_word = e.data;
            if (e.src) cnt1_m = (cnt1_m + 1) % (1 << CW);
            else       cnt0_m = (cnt0_m + 1) % (1 << CW);
            if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
        if (p0 || p1) begin
            src = p1;
            if (!empty_d0 && !empty_d1)
                check("arbiter", 32'(src), 32'((run_len >= BURST) ? !last_src : last_src));
            if (src == last_src) run_len++;
            else begin
                last_src = src;
                run_len  = 1;
            end
            if (src && q1.size() > 0)       w = q1.pop_front();
            else if (!src && q0.size() > 0) w = q0.pop_front();
            e.src = src; e.data = w; e.cyc = cyc;
            sb.push_back(e);
            pop_cyc.push_back(cyc);
            pop_src_log.push_back(src);
            check("credit", 32'(sb.size() > 2), 32'd0);
        end
        if (reset) begin
            sb.delete();
            cnt0_m = 0; cnt1_m = 0; last_word = '0; last_src = 1'b0; run_len = 0;
        end
        @(posedge clk);
        #1;
        idle_m  = reset ? 1'b1 : (!enable && (idle_m || (!run_m && occ == 0)));
        run_m   = !reset && enable;
        data_d0 = p0 ? w : DW'($urandom);
        data_d1 = p1 ? w : DW'($urandom);
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && (q0.size() + q1.size() + sb.size()) != 0; k++) step();
    endtask

    initial begin
        bit [7:0] pat;
        int       n, ca;
        reset = 1'b1; enable = 1'b1; stall = 1'b0;
        empty_d0 = 1'b1; empty_d1 = 1'b1; data_d0 = '0; data_d1 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with enable high: nothing moves, idle reported.
        repeat (3) step();
        check("t1_idle", 32'(idle_out), 32'd1);
        check("t1_valid", 32'(valid_out), 32'd0);
        check("t1_pops", 32'({pop_d0, pop_d1}), 32'd0);

        // Single source stream, back-to-back pops with two-cycle latency.
        for (int i = 1; i <= 5; i++) q0.push_back(DW'(i));
        pop_cyc.delete();
        lat_chk = 1'b1;
        reset = 1'b0;
        ca = cyc + 1;
        repeat (10) step();
        check("t2_npops", 32'(pop_cyc.size()), 32'd5);
        for (int i = 0; i < pop_cyc.size(); i++) check("t2_pop_cyc", 32'(pop_cyc[i]), 32'(ca + 1 + i));
        check("t2_cnt_d0", 32'(cnt_d0), 32'd5);

        // Both sources deep: bursts of two alternate.
        reset = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(DW'(8'h10 + i));
            q1.push_back(DW'(8'h20 + i));
        end
        pop_src_log.delete();
        reset = 1'b0;
        repeat (30) step();
        pat = 8'b1100_1100;
        for (int i = 0; i < 8; i++) check("t3_order", 32'(pop_src_log[i]), 32'(pat[i]));

        // Long stall mid-stream: credits cap pops, nothing lost afterwards.
        for (int i = 0; i < 20; i++) q0.push_back(DW'($urandom));
        repeat (4) step();
        lat_chk = 1'b0;
        stall = 1'b1;
        n = pop_cyc.size();
        repeat (10) step();
        check("t4_stall_pops", 32'(pop_cyc.size() - n > 2), 32'd0);
        stall = 1'b0;
        drain(60);
        check("t4_drained", 32'(sb.size() + q0.size()), 32'd0);

        // enable drops with words in flight: they drain, then idle.
        for (int i = 0; i < 8; i++) q0.push_back(DW'($urandom));
        step();
        step();
        enable = 1'b0;
        n = pop_cyc.size();
        for (int k = 0; k < 12 && !idle_out; k++) step();
        check("t5_idle", 32'(idle_out), 32'd1);
        check("t5_nopops", 32'(pop_cyc.size() - n), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Counter wrap on D1, then a reset in the middle of a stream.
        enable = 1'b1;
        reset = 1'b1;
        step();
        q0.delete();
        for (int i = 0; i < 17; i++) q1.push_back(DW'($urandom));
        reset = 1'b0;
        drain(60);
        check("t6_cnt_d1_wrap", 32'(cnt_d1), 32'd1);
        for (int i = 0; i < 10; i++) q0.push_back(DW'($urandom));
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_valid_after_reset", 32'(valid_out), 32'd0);
        check("t6_cnt_after_reset", 32'(cnt_d0), 32'd0);
        drain(60);

        // Random traffic, stalls and enable drops.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom % 3 == 0 && q0.size() < 8) q0.push_back(DW'($urandom));
            if ($urandom % 3 == 0 && q1.size() < 8) q1.push_back(DW'($urandom));
            stall  = ($urandom % 4 == 0);
            enable = ($urandom % 20 != 0);
            step();
        end
        stall = 1'b0;
        enable = 1'b1;
        drain(200);
        check("rand_drained", 32'(sb.size() + q0.size() + q1.size()), 32'd0);
        enable = 1'b0;
        repeat (6) step();
        check("rand_idle", 32'(idle_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
